pp_mbuf_st3: RTL and testbench

- Generalised successor to the stage-3 ping-pong buffer.
- Holds BANK_NUM wide banks (2 = classic ping-pong, 3+ = multi-buffer) filled by narrow multi-channel writes and drained as full-width rows.
- Replaces the external sel toggle with internal write/read bank pointers, an occupancy count, commit/release handshakes and a pipelined read-valid.
- Sits between the stage-2 narrow producer and the wide stage-3 consumer of the encoder.

---
 rtl/pp_mbuf_st3.sv | 163 ++++++++++++++++
 tb/tb_pp_mbuf_st3.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_mbuf_st3.sv
// pp_mbuf_st3: stage-3 multi-bank buffer between the narrow stage-2 producer and the wide
// stage-3 consumer. BANK_NUM wide banks are filled by multi-channel column beats (channel i
// lands in row i) and drained as full-width rows through a LATENCY-deep read pipeline.
// Write/read bank pointers and an occupancy count replace an external bank-select toggle.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_valid_i/_ready_o   write beat handshake; wr_ready_o = count < BANK_NUM
//   wr_data_i          one IN_DATA_WIDTH beat per channel
//   wr_addr_i          column index of the beat
//   wr_last_i          with an accepted beat, commits the current write bank
//   rd_avail_o         at least one committed bank
//   rd_req_i/rd_addr_i read row rd_addr_i of the current read bank
//   rd_release_i       release the current read bank
//   rd_valid_o/rd_data_o  read result, LATENCY cycles after the request; data held otherwise
//   bank_cnt_o         committed-bank count
//   err_wr_ovf_o       sticky: write attempted while full
//   err_rd_udf_o       sticky: read or release attempted while empty
//
// Optional feature: define PP_ST3_ERR_CHK_EN to build the sticky error flags; otherwise both
// error outputs are tied low.
//
// OUT_DATA_WIDTH must equal IN_DATA_WIDTH * 2**IN_ADDR_WIDTH and CHANNEL_NUM must not
// exceed 2**OUT_ADDR_WIDTH.
module pp_mbuf_st3 #(
  parameter int unsigned IN_DATA_WIDTH  = 64,
  parameter int unsigned IN_ADDR_WIDTH  = 7,
  parameter int unsigned OUT_DATA_WIDTH = 8192,
  parameter int unsigned OUT_ADDR_WIDTH = 2,
  parameter int unsigned CHANNEL_NUM    = 4,
  parameter int unsigned BANK_NUM       = 2,
  parameter int unsigned LATENCY        = 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      wr_valid_i,
  output logic                                      wr_ready_o,
  input  logic [CHANNEL_NUM-1:0][IN_DATA_WIDTH-1:0] wr_data_i,
  input  logic [IN_ADDR_WIDTH-1:0]                  wr_addr_i,
  input  logic                                      wr_last_i,
  output logic                                      rd_avail_o,
  input  logic                                      rd_req_i,
  input  logic [OUT_ADDR_WIDTH-1:0]                 rd_addr_i,
  input  logic                                      rd_release_i,
  output logic                                      rd_valid_o,
  output logic [OUT_DATA_WIDTH-1:0]                 rd_data_o,
  output logic [$clog2(BANK_NUM+1)-1:0]             bank_cnt_o,
  output logic                                      err_wr_ovf_o,
  output logic                                      err_rd_udf_o
);

  localparam int unsigned PtrW = $clog2(BANK_NUM);
  localparam int unsigned CntW = $clog2(BANK_NUM + 1);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [OUT_DATA_WIDTH-1:0] mem_q [BANK_NUM][CHANNEL_NUM];

  logic [OUT_DATA_WIDTH-1:0] pipe_data_q [LATENCY];
  logic [LATENCY-1:0]        pipe_vld_q;

  logic                      wr_acc, commit, rd_acc, release_acc;
  logic [OUT_DATA_WIDTH-1:0] rd_row;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BANK_NUM - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Ready/avail decode straight from the count register: no path from rd_release_i.
  assign wr_ready_o = (cnt_q != CntW'(BANK_NUM));
  assign rd_avail_o = (cnt_q != '0);
  assign bank_cnt_o = cnt_q;

  assign wr_acc      = wr_valid_i & wr_ready_o;
  assign commit      = wr_acc & wr_last_i;
  assign rd_acc      = rd_req_i & rd_avail_o;
  assign release_acc = rd_release_i & rd_avail_o;

  always_comb begin
    wptr_d = commit ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = release_acc ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({commit, release_acc})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bank storage is not reset. While count is strictly between 0 and BANK_NUM the write
  // and read pointers differ, and when full no write is accepted, so the same-cycle write
  // never touches the bank being read.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
        mem_q[wptr_q][c][IN_DATA_WIDTH*wr_addr_i +: IN_DATA_WIDTH] <= wr_data_i[c];
      end
    end
  end

  // Row mux; addresses with no backing channel read as zero.
  always_comb begin
    rd_row = '0;
    for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
      if (rd_addr_i == OUT_ADDR_WIDTH'(c)) rd_row = mem_q[rptr_q][c];
    end
  end

  // Data is captured at issue, so a release and refill of the bank cannot disturb reads
  // already in flight. Each stage only loads on valid, which keeps the last stage (the
  // output) holding its previous value between results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) pipe_data_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_acc;
      if (rd_acc) pipe_data_q[0] <= rd_row;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        if (pipe_vld_q[k-1]) pipe_data_q[k] <= pipe_data_q[k-1];
      end
    end
  end

  assign rd_valid_o = pipe_vld_q[LATENCY-1];
  assign rd_data_o  = pipe_data_q[LATENCY-1];

`ifdef PP_ST3_ERR_CHK_EN
  logic err_wr_ovf_q, err_rd_udf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_wr_ovf_q <= 1'b0;
      err_rd_udf_q <= 1'b0;
    end else begin
      if (wr_valid_i & ~wr_ready_o) err_wr_ovf_q <= 1'b1;
      if ((rd_req_i | rd_release_i) & ~rd_avail_o) err_rd_udf_q <= 1'b1;
    end
  end

  assign err_wr_ovf_o = err_wr_ovf_q;
  assign err_rd_udf_o = err_rd_udf_q;
`else
  assign err_wr_ovf_o = 1'b0;
  assign err_rd_udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_pp_mbuf_st3.sv
// Self-checking bench for pp_mbuf_st3: directed scenarios followed by random traffic, checked
// by a scoreboard fed from a bank-image reference model.
module tb_pp_mbuf_st3;

  localparam int IDW  = 16;
  localparam int IAW  = 3;
  localparam int NCOL = 1 << IAW;
  localparam int ODW  = IDW * NCOL;
  localparam int OAW  = 3;
  localparam int CH   = 4;
  localparam int BN   = 3;
  localparam int LAT  = 3;
  localparam int CW   = $clog2(BN + 1);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    wr_valid = 1'b0;
  logic                    wr_ready;
  logic [CH-1:0][IDW-1:0]  wr_data = '0;
  logic [IAW-1:0]          wr_addr = '0;
  logic                    wr_last = 1'b0;
  logic                    rd_avail;
  logic                    rd_req = 1'b0;
  logic [OAW-1:0]          rd_addr = '0;
  logic                    rd_release = 1'b0;
  logic                    rd_valid;
  logic [ODW-1:0]          rd_data;
  logic [CW-1:0]           bank_cnt;
  logic                    err_wr_ovf;
  logic                    err_rd_udf;

  always #5 clk = ~clk;

  pp_mbuf_st3 #(
    .IN_DATA_WIDTH (IDW),
    .IN_ADDR_WIDTH (IAW),
    .OUT_DATA_WIDTH(ODW),
    .OUT_ADDR_WIDTH(OAW),
    .CHANNEL_NUM   (CH),
    .BANK_NUM      (BN),
    .LATENCY       (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .wr_addr_i   (wr_addr),
    .wr_last_i   (wr_last),
    .rd_avail_o  (rd_avail),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .rd_release_i(rd_release),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .bank_cnt_o  (bank_cnt),
    .err_wr_ovf_o(err_wr_ovf),
    .err_rd_udf_o(err_rd_udf)
  );

  int     n_chk = 0;
  int     n_err = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: physical bank images plus FIFO-style occupancy.
  int             m_cnt, m_wp, m_rp;
  bit             m_ovf, m_udf;
  logic [ODW-1:0] img [BN][CH];

  typedef struct {
    logic [ODW-1:0] data;
    longint         due;
  } exp_t;

  exp_t           sb[$];
  logic [ODW-1:0] hold_exp = '0;
  bit             mon_en = 1'b0;

  task automatic chk(input string nm, input logic [ODW-1:0] act, input logic [ODW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [IDW-1:0] pat(input int tag, input int ch, input int col);
    logic [IDW-1:0] v;
    v = {4'(tag), 4'(ch), 8'(col)};
    return v;
  endfunction

  // Monitor: status every cycle, read results popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      chk("wr_ready", {127'd0, wr_ready}, {127'd0, m_cnt < BN});
      chk("rd_avail", {127'd0, rd_avail}, {127'd0, m_cnt > 0});
      chk("bank_cnt", ODW'(bank_cnt), ODW'(m_cnt));
`ifdef PP_ST3_ERR_CHK_EN
      chk("err_wr_ovf", {127'd0, err_wr_ovf}, {127'd0, m_ovf});
      chk("err_rd_udf", {127'd0, err_rd_udf}, {127'd0, m_udf});
`else
      chk("err_wr_ovf", {127'd0, err_wr_ovf}, '0);
      chk("err_rd_udf", {127'd0, err_rd_udf}, '0);
`endif
      if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_valid_unexpected", {127'd0, rd_valid}, '0);
        end else begin
          e = sb.pop_front();
          chk("rd_latency", ODW'(cyc), ODW'(e.due));
          chk("rd_data", rd_data, e.data);
          hold_exp = e.data;
        end
      end else begin
        chk("rd_data_hold", rd_data, hold_exp);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("rd_valid_missing", {127'd0, rd_valid}, {127'd0, 1'b1});
        end
      end
    end
  end

  // One clock of stimulus; the model is advanced just after the edge that samples it.
  task automatic step(input bit wv, input logic [CH-1:0][IDW-1:0] wd, input int wa,
                      input bit wl, input bit rq, input int ra, input bit rl);
    bit   wacc, racc, rel, ovf_ev, udf_ev;
    exp_t e;
    @(negedge clk);
    wr_valid   = wv;
    wr_data    = wd;
    wr_addr    = IAW'(wa);
    wr_last    = wl;
    rd_req     = rq;
    rd_addr    = OAW'(ra);
    rd_release = rl;
    wacc   = wv && (m_cnt < BN);
    racc   = rq && (m_cnt > 0);
    rel    = rl && (m_cnt > 0);
    ovf_ev = wv && (m_cnt == BN);
    udf_ev = (rq || rl) && (m_cnt == 0);
    if (racc) begin
      e.data = (ra < CH) ? img[m_rp][ra] : '0;
      e.due  = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (wacc) begin
      for (int c = 0; c < CH; c++) img[m_wp][c][IDW*wa +: IDW] = wd[c];
      if (wl) begin
        m_wp = (m_wp + 1) % BN;
        m_cnt++;
      end
    end
    if (rel) begin
      m_rp = (m_rp + 1) % BN;
      m_cnt--;
    end
    if (ovf_ev) m_ovf = 1'b1;
    if (udf_ev) m_udf = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, '0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Write every column of the current write bank with tagged data, committing on the last.
  task automatic fill(input int tag, input bit rl_on_last);
    logic [CH-1:0][IDW-1:0] wd;
    for (int col = 0; col < NCOL; col++) begin
      for (int c = 0; c < CH; c++) wd[c] = pat(tag, c, col);
      step(1'b1, wd, col, col == NCOL - 1, 1'b0, 0, rl_on_last && (col == NCOL - 1));
    end
  endtask

  task automatic read_row(input int ra);
    step(1'b0, '0, 0, 1'b0, 1'b1, ra, 1'b0);
  endtask

  task automatic release_bank();
    step(1'b0, '0, 0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    if (mon_en) begin
      chk("rst_bank_cnt", ODW'(bank_cnt), '0);
      chk("rst_rd_valid", {127'd0, rd_valid}, '0);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_wr_ready", {127'd0, wr_ready}, {127'd0, 1'b1});
      chk("rst_rd_avail", {127'd0, rd_avail}, '0);
    end
    m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_udf = 1'b0;
    sb.delete();
    hold_exp   = '0;
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    rd_req     = 1'b0;
    rd_release = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CH-1:0][IDW-1:0] wd;
    logic [ODW-1:0]         row;
    do_reset();
    mon_en = 1'b1;
    idle();

    // Single bank: every row reads back {ch, col} per column; one row past CHANNEL_NUM is 0.
    fill(0, 1'b0);
    chk("t1_bank_cnt", ODW'(bank_cnt), ODW'(1));
    for (int r = 0; r < CH; r++) read_row(r);
    read_row(CH + 1);
    for (int k = 0; k < NCOL; k++) row[IDW*k +: IDW] = pat(0, 2, k);
    chk("t1_model_row2", img[0][2], row);
    repeat (LAT) idle();

    // Fill to full, attempt an overflow write, then release one bank.
    fill(1, 1'b0);
    fill(2, 1'b0);
    chk("t2_full_ready", {127'd0, wr_ready}, '0);
    chk("t2_full_cnt", ODW'(bank_cnt), ODW'(BN));
    for (int c = 0; c < CH; c++) wd[c] = 16'hdead;
    step(1'b1, wd, 0, 1'b1, 1'b0, 0, 1'b0);
    release_bank();
    chk("t2_rel_ready", {127'd0, wr_ready}, {127'd0, 1'b1});
    chk("t2_rel_cnt", ODW'(bank_cnt), ODW'(BN - 1));

    // Back to full, then read, release, and immediately refill the released bank.
    fill(3, 1'b0);
    read_row(2);
    release_bank();
    fill(4, 1'b0);
    repeat (LAT) idle();

    // Drain to one bank, then commit and release together.
    while (m_cnt > 1) release_bank();
    fill(5, 1'b1);
    chk("t3_cnt_same", ODW'(bank_cnt), ODW'(1));
    read_row(1);
    read_row(3);
    repeat (LAT) idle();

    // Underflow: read and release while empty.
    while (m_cnt > 0) release_bank();
    step(1'b0, '0, 0, 1'b0, 1'b1, 0, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 1, 1'b1);
    repeat (LAT + 1) idle();

    // Random traffic: write-heavy phase, then read-heavy phase.
    for (int n = 0; n < 1600; n++) begin
      for (int c = 0; c < CH; c++) wd[c] = IDW'($urandom);
      step($urandom_range(0, 3) != 0, wd, int'($urandom_range(0, NCOL - 1)),
           (n < 800) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 11) == 0),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, (1 << OAW) - 1)),
           (n < 800) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 5) == 0));
    end
    repeat (LAT) idle();

    // Reset with two banks committed and a read in flight.
    while (m_cnt > 0) release_bank();
    fill(10, 1'b0);
    fill(11, 1'b0);
    read_row(0);
    do_reset();
    repeat (LAT + 2) idle();
    fill(12, 1'b0);
    read_row(3);
    read_row(0);
    repeat (LAT + 2) idle();

    chk("sb_drained", ODW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
